// File: rtl/rv32i_lsu.sv
// rv32i_lsu: load/store unit acting as initiator on a byte-lane memory bus.
// It takes one load or store at a time from the core and rejects misaligned
// accesses or an illegal size without touching the bus. It runs a single bus
// transaction with wait states and a timeout, then returns extended load data
// or an error code.
module rv32i_lsu #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_err,
    output logic        breq,
    output logic [31:0] baddr,
    output logic [1:0]  bsz,
    output logic [31:0] bdi,
    output logic        bwr,
    input  logic [31:0] bdo,
    input  logic        bus_ack
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_ALIGN   = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUS  = 2'b01,
        RESP = 2'b10
    } state_t;

    state_t          state;
    state_t          state_nxt;

    // Request fields captured at accept time. They drive the bus directly,
    // so the bus outputs hold steady for the whole transaction.
    logic            op_we;
    logic [31:0]     op_addr;
    logic [1:0]      op_size;
    logic            op_uns;
    logic [31:0]     op_wdata;

    logic [CW-1:0]   wait_cnt;
    logic            timeout_hit;
    logic            misaligned;
    logic [31:0]     load_ext;

    // Sign- or zero-extend the right-justified bus read data to 32 bits.
    // Bits above the access size are ignored.
    function automatic logic [31:0] extend_load(input logic [31:0] raw,
                                                input logic [1:0]  size,
                                                input logic        uns);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic [31:0]        res;
        b = signed'(raw[7:0]);
        h = signed'(raw[15:0]);
        case (size)
            2'b00:   res = uns ? {24'h0, raw[7:0]}  : {{24{b[7]}}, raw[7:0]};
            2'b01:   res = uns ? {16'h0, raw[15:0]} : {{16{h[15]}}, raw[15:0]};
            default: res = raw;
        endcase
        return res;
    endfunction

    assign misaligned  = ((req_size == 2'b01) && req_addr[0]) ||
                         ((req_size == 2'b10) && (req_addr[1:0] != 2'b00)) ||
                         (req_size == 2'b11);
    assign timeout_hit = (wait_cnt == CW'(TIMEOUT - 1));
    assign load_ext    = extend_load(bdo, op_size, op_uns);

    assign baddr = op_addr;
    assign bsz   = op_size;
    assign bdi   = op_wdata;

    // State register; the async reset returns to IDLE so breq/bwr fall at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake/bus strobes decoded from the current state.
    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        breq      = 1'b0;
        bwr       = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_nxt = misaligned ? RESP : BUS;
                end
            end
            BUS: begin
                breq = 1'b1;
                bwr  = op_we;
                if (bus_ack || timeout_hit) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Capture the request, count wait states and build the response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_we     <= 1'b0;
            op_addr   <= 32'h0;
            op_size   <= 2'b00;
            op_uns    <= 1'b0;
            op_wdata  <= 32'h0;
            wait_cnt  <= '0;
            rsp_rdata <= 32'h0;
            rsp_err   <= ERR_OK;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_we    <= req_we;
                        op_addr  <= req_addr;
                        op_size  <= req_size;
                        op_uns   <= req_unsigned;
                        op_wdata <= req_wdata;
                        wait_cnt <= '0;
                        if (misaligned) begin
                            rsp_rdata <= 32'h0;
                            rsp_err   <= ERR_ALIGN;
                        end
                    end
                end
                BUS: begin
                    // An ack arriving on the last allowed cycle beats the timeout.
                    if (bus_ack) begin
                        rsp_rdata <= op_we ? 32'h0 : load_ext;
                        rsp_err   <= ERR_OK;
                    end else if (timeout_hit) begin
                        rsp_rdata <= 32'h0;
                        rsp_err   <= ERR_TIMEOUT;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
